// File: rtl/ssc_acia_host.sv
// Host-side initiator for a 6551-style ACIA register port: programs the ACIA,
// polls status, and moves bytes between TX/RX streams and the data register.
module ssc_acia_host #(
    parameter int unsigned ACCESS_CYCLES = 4,
    parameter int unsigned POLL_GAP      = 8,
    parameter logic [7:0]  COMMAND_INIT  = 8'h0B,
    parameter logic [7:0]  CONTROL_INIT  = 8'h1E
) (
    input  logic       clk_logic,
    input  logic       system_reset_n,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic [7:0] overrun_count_o,
    output logic       init_done_o,
    output logic       acia_cs_o,
    output logic       acia_rw_n_o,
    output logic [1:0] acia_rs_o,
    output logic [7:0] acia_di_o,
    input  logic [7:0] acia_do_i
);

    localparam int unsigned CNT_MAX = (ACCESS_CYCLES > POLL_GAP) ? ACCESS_CYCLES : POLL_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(POLL_GAP - 1);

    localparam int unsigned ST_OVR  = 2;
    localparam int unsigned ST_RDRF = 3;
    localparam int unsigned ST_TDRE = 4;

    localparam logic [1:0] RS_DATA   = 2'b00;
    localparam logic [1:0] RS_STATUS = 2'b01;
    localparam logic [1:0] RS_CMD    = 2'b10;
    localparam logic [1:0] RS_CTL    = 2'b11;

    typedef enum logic [2:0] {
        S_INIT_RST,
        S_INIT_CMD,
        S_INIT_CTL,
        S_GAP,
        S_POLL,
        S_RD_DATA,
        S_WR_DATA
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       hold_data;
    logic             hold_full;

    logic [1:0]       acc_rs;
    logic             acc_rw_n;
    logic [7:0]       acc_di;

    // Bus values for the access the current state performs
    always_comb begin
        acc_rs   = RS_DATA;
        acc_rw_n = 1'b1;
        acc_di   = 8'h00;
        case (state)
            S_INIT_RST: begin
                acc_rs   = RS_STATUS;
                acc_rw_n = 1'b0;
            end
            S_INIT_CMD: begin
                acc_rs   = RS_CMD;
                acc_rw_n = 1'b0;
                acc_di   = COMMAND_INIT;
            end
            S_INIT_CTL: begin
                acc_rs   = RS_CTL;
                acc_rw_n = 1'b0;
                acc_di   = CONTROL_INIT;
            end
            S_POLL: acc_rs = RS_STATUS;
            S_WR_DATA: begin
                acc_rw_n = 1'b0;
                acc_di   = hold_data;
            end
            default: ;
        endcase
    end

    // Sequencer: cnt==0 launches an access, cnt==ACCESS_CYCLES ends it (cs-low clock follows)
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state           <= S_INIT_RST;
            cnt             <= '0;
            hold_data       <= 8'h00;
            hold_full       <= 1'b0;
            tx_ready_o      <= 1'b0;
            rx_data_o       <= 8'h00;
            rx_valid_o      <= 1'b0;
            overrun_count_o <= 8'h00;
            init_done_o     <= 1'b0;
            acia_cs_o       <= 1'b0;
            acia_rw_n_o     <= 1'b1;
            acia_rs_o       <= 2'b00;
            acia_di_o       <= 8'h00;
        end else begin
            rx_valid_o <= 1'b0;

            // Ready lags the holding register by one clock so it never rises on the clearing edge
            if (tx_valid_i && tx_ready_o) begin
                hold_data  <= tx_data_i;
                hold_full  <= 1'b1;
                tx_ready_o <= 1'b0;
            end else begin
                tx_ready_o <= init_done_o && !hold_full;
            end

            if (state == S_GAP) begin
                if (cnt == GAP_LAST) begin
                    state <= S_POLL;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (cnt == '0) begin
                acia_cs_o   <= 1'b1;
                acia_rs_o   <= acc_rs;
                acia_rw_n_o <= acc_rw_n;
                acia_di_o   <= acc_di;
                cnt         <= CNT_W'(1);
            end else if (cnt == ACC_LAST) begin
                acia_cs_o   <= 1'b0;
                acia_rs_o   <= 2'b00;
                acia_rw_n_o <= 1'b1;
                acia_di_o   <= 8'h00;
                cnt         <= '0;
                case (state)
                    S_INIT_RST: state <= S_INIT_CMD;
                    S_INIT_CMD: state <= S_INIT_CTL;
                    S_INIT_CTL: begin
                        init_done_o <= 1'b1;
                        state       <= S_GAP;
                    end
                    S_POLL: begin
                        if (acia_do_i[ST_OVR] && (overrun_count_o != 8'hFF)) begin
                            overrun_count_o <= overrun_count_o + 8'd1;
                        end
                        // Receive wins; a pending write waits for a later poll
                        if (acia_do_i[ST_RDRF]) begin
                            state <= S_RD_DATA;
                        end else if (acia_do_i[ST_TDRE] && hold_full) begin
                            state <= S_WR_DATA;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                    S_RD_DATA: begin
                        rx_data_o  <= acia_do_i;
                        rx_valid_o <= 1'b1;
                        state      <= S_GAP;
                    end
                    S_WR_DATA: begin
                        hold_full <= 1'b0;
                        state     <= S_GAP;
                    end
                    default: state <= S_GAP;
                endcase
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ssc_acia_host.sv
// Scoreboard bench for ssc_acia_host: a small ACIA register model answers reads,
// monitors check completed bus accesses and RX pulses against expectation queues.
module tb_ssc_acia_host;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] ovr;
    logic       init_done;
    logic       acia_cs;
    logic       acia_rw_n;
    logic [1:0] acia_rs;
    logic [7:0] acia_di;
    logic [7:0] acia_do;

    logic [7:0] status;
    logic [7:0] data_reg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ssc_acia_host dut (
        .clk_logic       (clk),
        .system_reset_n  (rst_n),
        .tx_data_i       (tx_data),
        .tx_valid_i      (tx_valid),
        .tx_ready_o      (tx_ready),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .overrun_count_o (ovr),
        .init_done_o     (init_done),
        .acia_cs_o       (acia_cs),
        .acia_rw_n_o     (acia_rw_n),
        .acia_rs_o       (acia_rs),
        .acia_di_o       (acia_di),
        .acia_do_i       (acia_do)
    );

    // ACIA register model: status at RS=01, receive data at RS=00
    assign acia_do = (acia_rs == 2'b01) ? status :
                     (acia_rs == 2'b00) ? data_reg : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {rs, rw_n, di, cs-high clocks, stable}
    function automatic logic [19:0] mk(input logic [1:0] rs, input logic rw, input logic [7:0] di);
        return {rs, rw, di, 8'd4, 1'b1};
    endfunction

    logic [19:0] exp_acc[$];
    logic [7:0]  exp_rx[$];

    logic       in_acc = 1'b0;
    logic [1:0] m_rs;
    logic       m_rw;
    logic [7:0] m_di;
    int         m_hi;
    logic       m_st;
    int         poll_cnt = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         last_poll_cyc = 0;

    // Access monitor: status polls are counted, every other access must match the queue
    always @(negedge clk) begin
        if (!rst_n) begin
            in_acc = 1'b0;
        end else if (acia_cs) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                m_rs = acia_rs;
                m_rw = acia_rw_n;
                m_di = acia_di;
                m_hi = 1;
                m_st = 1'b1;
            end else begin
                m_hi++;
                if ({acia_rs, acia_rw_n, acia_di} != {m_rs, m_rw, m_di}) m_st = 1'b0;
            end
        end else if (in_acc) begin
            in_acc = 1'b0;
            chk("idle_bus", 32'({acia_rs, acia_rw_n, acia_di}), 32'({2'b00, 1'b1, 8'h00}));
            if (m_rs == 2'b01 && m_rw) begin
                chk("poll_high_len", 32'(m_hi), 32'd4);
                poll_cnt++;
                last_poll_cyc = cyc;
            end else begin
                chk("access_expected", 32'(exp_acc.size() != 0), 32'd1);
                if (exp_acc.size() != 0)
                    chk("access", 32'({m_rs, m_rw, m_di, 8'(m_hi), m_st}), 32'(exp_acc.pop_front()));
                if (m_rw) rd_cnt++;
                else wr_cnt++;
            end
        end
    end

    logic prev_rxv = 1'b0;
    int   rx_cnt = 0;

    // RX monitor: single-clock pulse, data, and latency from the status sample
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rxv = 1'b0;
        end else begin
            if (rx_valid) begin
                chk("rx_single_pulse", 32'(prev_rxv), 32'd0);
                chk("rx_expected", 32'(exp_rx.size() != 0), 32'd1);
                if (exp_rx.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
                chk("rx_latency", 32'(cyc - last_poll_cyc), 32'd5);
                rx_cnt++;
            end
            prev_rxv = rx_valid;
        end
    end

    task automatic wait_polls(input int n);
        int target = poll_cnt + n;
        int k = 0;
        while (poll_cnt < target && k < n * 40) begin
            @(negedge clk);
            k++;
        end
        chk("poll_wait", 32'(poll_cnt >= target), 32'd1);
    endtask

    task automatic wait_rx();
        int r0 = rx_cnt;
        int k = 0;
        while (rx_cnt == r0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rx_seen", 32'(rx_cnt - r0), 32'd1);
    endtask

    task automatic wait_wr_start();
        int k = 0;
        while (!(acia_cs && !acia_rw_n) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("wr_start_seen", 32'(acia_cs && !acia_rw_n), 32'd1);
    endtask

    task automatic run_init();
        int n;
        exp_acc.push_back(mk(2'b01, 1'b0, 8'h00));
        exp_acc.push_back(mk(2'b10, 1'b0, 8'h0B));
        exp_acc.push_back(mk(2'b11, 1'b0, 8'h1E));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_cs", 32'(acia_cs), 32'd1);
        n = 1;
        while (!init_done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("init_done_clock", 32'(n), 32'd15);
        chk("tx_ready_at_init_done", 32'(tx_ready), 32'd0);
        @(posedge clk); #1;
        chk("tx_ready_after_init", 32'(tx_ready), 32'd1);
    endtask

    initial begin
        int n;
        int p0;
        int w0;
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        status   = 8'h00;
        data_reg = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bus", 32'({acia_cs, acia_rw_n, acia_rs, acia_di}), 32'({1'b0, 1'b1, 2'b00, 8'h00}));
        chk("reset_flags", 32'({tx_ready, rx_valid, init_done, rx_data, ovr}), 32'd0);

        run_init();

        // TX byte, written once TDRE is seen
        tx_data  = 8'h41;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        chk("tx_ready_after_accept", 32'(tx_ready), 32'd0);
        exp_acc.push_back(mk(2'b00, 1'b0, 8'h41));
        status = 8'h10;
        wait_wr_start();
        chk("tx_ready_during_wr", 32'(tx_ready), 32'd0);
        n = 0;
        while (acia_cs && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr_high_len", 32'(n), 32'd4);
        chk("tx_ready_at_wr_end", 32'(tx_ready), 32'd0);
        @(negedge clk);
        chk("tx_ready_after_wr", 32'(tx_ready), 32'd1);
        status = 8'h00;

        // RX byte
        data_reg = 8'h5A;
        exp_acc.push_back(mk(2'b00, 1'b1, 8'h00));
        exp_rx.push_back(8'h5A);
        status = 8'h08;
        wait_rx();
        status = 8'h00;

        // RDRF and TDRE together: read now, write on the following poll
        @(negedge clk);
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        data_reg = 8'hC3;
        exp_acc.push_back(mk(2'b00, 1'b1, 8'h00));
        exp_acc.push_back(mk(2'b00, 1'b0, 8'h77));
        exp_rx.push_back(8'hC3);
        status = 8'h18;
        wait_rx();
        p0 = poll_cnt;
        w0 = wr_cnt;
        status = 8'h10;
        n = 0;
        while (wr_cnt == w0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("prio_write_done", 32'(wr_cnt - w0), 32'd1);
        chk("polls_between_rd_wr", 32'(poll_cnt - p0), 32'd1);
        status = 8'h00;

        // Overrun counting and saturation
        wait_polls(1);
        status = 8'h04;
        wait_polls(10);
        chk("overrun_10", 32'(ovr), 32'd10);
        wait_polls(290);
        chk("overrun_sat", 32'(ovr), 32'd255);
        wait_polls(5);
        chk("overrun_hold", 32'(ovr), 32'd255);
        status = 8'h00;

        // Reset during the 2nd cs-high clock of a data write
        @(negedge clk);
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        status = 8'h10;
        wait_wr_start();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_bus", 32'({acia_cs, acia_rw_n, acia_rs, acia_di}), 32'({1'b0, 1'b1, 2'b00, 8'h00}));
        chk("reset_async_flags", 32'({tx_ready, init_done, rx_valid, rx_data, ovr}), 32'd0);
        repeat (2) @(posedge clk);
        run_init();
        wait_polls(3);
        chk("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
        chk("rx_queue_drained", 32'(exp_rx.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssc_acia_host.md
# ssc_acia_host

Host-side driver for a 6551-compatible ACIA register port: the initiator end of the register bus the Super Serial Card's UART responds to. It programs the ACIA after reset, polls status, and moves bytes between a valid/ready TX stream, a pulsed RX stream and the ACIA data register. It is used for on-FPGA loopback and bring-up of the SSC UART path, and as a console bridge where no 6502 drives the ACIA.

## Interface
- ACCESS_CYCLES, 4: clocks CS is held per register access; legal range ≥2.
- POLL_GAP, 8: idle clocks between the end of one poll iteration and the next status read; legal range ≥1.
- COMMAND_INIT, 8'h0B: value written to the command register (RS=2'b10) during init.
- CONTROL_INIT, 8'h1E: value written to the control register (RS=2'b11) during init; 8'h1E selects 9600 baud, 8N1.

Ports:
- clk_logic  in  1  single clock for all logic.
- system_reset_n  in  1  reset, asynchronous, active-low.
- tx_data_i  in  8  byte to transmit.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  holding register empty and init complete.
- rx_data_o  out  8  last received byte; held until the next receive.
- rx_valid_o  out  1  one-clock pulse when rx_data_o updates.
- overrun_count_o  out  8  count of status reads with bit2 (overrun) set; saturates at 255.
- init_done_o  out  1  high once the init sequence has completed.
- acia_cs_o  out  1  ACIA chip select, active-high.
- acia_rw_n_o  out  1  1 = read, 0 = write.
- acia_rs_o  out  2  register select.
- acia_di_o  out  8  write data to the ACIA.
- acia_do_i  in  8  read data from the ACIA.

## Operation
- Register bus access: rs, rw_n and di are driven stable for the whole access, and cs is high for exactly ACCESS_CYCLES clocks. Read data is sampled on the clock edge that ends the final cs-high cycle. cs is then low for at least 1 clock before the next access.
- Idle bus state: cs=0, rw_n=1, rs=0, di=0.
- FSM states: INIT_RST → INIT_CMD → INIT_CTL → GAP → POLL → {RD_DATA | WR_DATA} → GAP.
  - INIT_RST: writes 8'h00 to RS=01 (programmed reset).
  - INIT_CMD: writes COMMAND_INIT to RS=10.
  - INIT_CTL: writes CONTROL_INIT to RS=11. init_done_o rises on the clock after this access's cs falls and stays high until reset.
  - GAP: counts POLL_GAP clocks with the bus idle.
  - POLL: reads status (RS=01).
    - bit3 (RDRF)=1 → RD_DATA.
    - Otherwise, bit4 (TDRE)=1 and holding register full → WR_DATA.
    - Otherwise → GAP.
  - Overrun: if status bit2=1, overrun_count_o increments by 1 (saturating at 255), regardless of the branch taken.
  - RD_DATA: reads RS=00. rx_data_o is loaded with the sampled byte and rx_valid_o pulses on the clock after the sample edge.
  - WR_DATA: writes the holding register to RS=00. The holding register is cleared when the access's cs falls.
- Priority: at most one data access per poll. RX is served first: with RDRF=1 and TDRE=1, the read happens now and the write happens on a later poll.
- TX holding register: one byte. A byte is accepted when tx_valid_i && tx_ready_o. tx_ready_o = init_done_o && !hold_full.
  - Acceptance while WR_DATA is in progress is impossible, because hold_full stays set until the write completes.
  - tx_ready_o rises on the clock after the holding register clears.
- Reset (asserted at any time, including mid-access):
  - Outputs immediately go to cs=0, rw_n=1, rs=0, di=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0, overrun_count_o=0, init_done_o=0.
  - The holding register is emptied and the FSM returns to INIT_RST.
  - After release, the first access starts on the first clock edge.

## Timing
- Each access occupies ACCESS_CYCLES+1 clocks, including the mandatory cs-low clock.
- Init: 3 accesses, so init_done_o rises 3*(ACCESS_CYCLES+1) clocks after reset release.
- Poll iteration:
  - POLL_GAP + (ACCESS_CYCLES+1) clocks with no data access.
  - POLL_GAP + 2*(ACCESS_CYCLES+1) clocks with one data access.
- RX latency: rx_valid_o pulses ACCESS_CYCLES+1 clocks after the status sample edge, i.e. after the RD_DATA access completes (cs falling counts as that access's final clock).
- rx_valid_o is never high on two consecutive clocks.
- Status sampled as RDRF=1 counts as one receive; no consistency check is done against the data read.

## Test plan
- Reset release with ACCESS_CYCLES=4 → writes (RS=01, 8'h00), (RS=10, 8'h0B), (RS=11, 8'h1E), each with cs high exactly 4 clocks; init_done_o rises at clock 15.
- tx_data_i=8'h41 accepted; model returns status 8'h10 → next poll is followed by a write of 8'h41 to RS=00; tx_ready_o is 0 during the write and 1 one clock after it ends.
- Status 8'h08, data register 8'h5A → rx_data_o=8'h5A with a single-clock rx_valid_o pulse, 5 clocks after the status sample.
- Status 8'h18 with a byte held → read first, no write in that iteration; write occurs on the next poll where status is 8'h10.
- Status 8'h04 returned on 300 polls → overrun_count_o reaches 255 and holds.
- Reset asserted on the 2nd cs-high clock of a WR_DATA access → cs drops without waiting for a clock edge; after release the init sequence restarts and the held byte is discarded (tx_ready_o=1 after init).
